// File: rtl/imem_loader_rv32i_if.sv
// Byte-stream input and instruction-memory write bus of the RV32I image loader.
// A byte moves on a rising edge where byte_valid and byte_ready are both high; byte_in must be stable while byte_valid is high.
interface imem_loader_rv32i_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_rv32i.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory as little-endian 32-bit words.
// state_dbg encodes IDLE=0, LEN_LO=1, LEN_HI=2, DATA=3, CHECK=4, DONE=5, ERROR=6.
module imem_loader_rv32i #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imem_loader_rv32i_if.slave  bus,
    output logic                core_rst_n,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         word_count,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] partial;
    logic [7:0]  checksum;
    logic        fire, start_load, len_bad, last_word;
    logic        ready_d, busy_d, done_d, error_d, core_rst_d;

    assign fire       = bus.byte_valid && bus.byte_ready;
    assign start_load = start && (state == IDLE || state == DONE || state == ERROR);
    assign len_bad    = ({bus.byte_in, len_lo} == 16'd0) ||
                        ({16'd0, bus.byte_in, len_lo} > MAX_N);
    // word_count still holds the index of the word being completed here
    assign last_word  = (byte_idx == 2'd3) && ((word_count + 16'd1) == len);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            core_rst_n     <= 1'b0;
        end else begin
            state          <= state_next;
            bus.byte_ready <= ready_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
            core_rst_n     <= core_rst_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_next = LEN_LO;
            LEN_LO:            if (fire) state_next = LEN_HI;
            LEN_HI:            if (fire) state_next = len_bad ? ERROR : DATA;
            DATA:              if (fire && last_word) state_next = CHECK;
            CHECK:             if (fire) state_next = (bus.byte_in == checksum) ? DONE : ERROR;
            default:           state_next = IDLE;
        endcase
    end

    // Flags are decoded from the next state so they register alongside it.
    always_comb begin
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        core_rst_d = 1'b0;
        case (state_next)
            LEN_LO, LEN_HI, DATA, CHECK: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d     = 1'b1;
                core_rst_d = 1'b1;
            end
            ERROR:   error_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 32'd0;
            bus.imem_wdata <= 32'd0;
            word_count     <= 16'd0;
            len_lo         <= 8'd0;
            len            <= 16'd0;
            byte_idx       <= 2'd0;
            partial        <= 24'd0;
            checksum       <= 8'd0;
        end else begin
            bus.imem_we <= 1'b0;
            if (bus.imem_we) word_count <= word_count + 16'd1;
            if (start_load) begin
                word_count <= 16'd0;
                checksum   <= 8'd0;
                byte_idx   <= 2'd0;
            end
            if (fire) begin
                case (state)
                    LEN_LO: len_lo <= bus.byte_in;
                    LEN_HI: len    <= {bus.byte_in, len_lo};
                    DATA: begin
                        checksum <= checksum ^ bus.byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: partial[7:0]   <= bus.byte_in;
                            2'd1: partial[15:8]  <= bus.byte_in;
                            2'd2: partial[23:16] <= bus.byte_in;
                            default: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_wdata <= {bus.byte_in, partial};
                                bus.imem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Randomised bench for imem_loader_rv32i: a stream-level model predicts writes and load outcome.
module tb_imem_loader_rv32i;
    typedef logic [7:0] byte_q_t[$];

    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam int          MAX_W    = 4;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_DONE  = 3'd5;
    localparam logic [2:0]  ST_ERROR = 3'd6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        core_rst_n, busy, done, error;
    logic [15:0] word_count;
    logic [2:0]  state_dbg;

    imem_loader_rv32i_if bif();

    imem_loader_rv32i #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bif),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .state_dbg  (state_dbg)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];
    logic        prev_we = 1'b0;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // behavioural model: whole-stream view of one load
    function automatic logic [7:0] data_xor(input byte_q_t s, input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= s[2 + i];
        return x;
    endfunction

    task automatic model_load(input byte_q_t s, output logic ok, output logic [15:0] wc);
        int n;
        n = {s[1], s[0]};
        if (n == 0 || n > MAX_W) begin
            ok = 1'b0;
            wc = 16'd0;
        end else begin
            for (int w = 0; w < n; w++)
                exp_q.push_back({BASE + 32'(4 * w),
                                 s[2 + 4*w + 3], s[2 + 4*w + 2], s[2 + 4*w + 1], s[2 + 4*w]});
            ok = (s[2 + 4 * n] == data_xor(s, n));
            wc = 16'(n);
        end
    endtask

    // scoreboard: every write must be the next predicted one, one cycle wide
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_eq_busy", {63'd0, bif.byte_ready}, {63'd0, busy});
            if (bif.imem_we) begin
                check("we_one_cycle", {63'd0, prev_we}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write actual=%0h_%0h required=none",
                             bif.imem_addr, bif.imem_wdata);
                end else begin
                    check("write", {bif.imem_addr, bif.imem_wdata}, exp_q.pop_front());
                end
                wr_log.push_back({bif.imem_addr, bif.imem_wdata});
            end
            prev_we = bif.imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {63'd0, busy}, 64'd1);
        check("start_core_rst_n", {63'd0, core_rst_n}, 64'd0);
        check("start_done", {63'd0, done}, 64'd0);
        check("start_error", {63'd0, error}, 64'd0);
        check("start_word_count", {48'd0, word_count}, 64'd0);
    endtask

    task automatic send_bytes(input byte_q_t s, input int gap_max);
        logic accepted;
        for (int i = 0; i < s.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                bif.byte_valid = 1'b0;
                @(negedge clk);
            end
            bif.byte_valid = 1'b1;
            bif.byte_in    = s[i];
            accepted = 1'b0;
            for (int t = 0; t < 50 && !accepted; t++) begin
                accepted = bif.byte_ready;
                @(negedge clk);
            end
            if (!accepted) begin
                n_checks++;
                n_errors++;
                $display("FAIL byte_accept_timeout actual=no_ready required=ready byte=%0d", i);
            end
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic run_load(input byte_q_t s, input int gap_max, input string tag);
        logic        ok;
        logic [15:0] wc;
        model_load(s, ok, wc);
        pulse_start();
        send_bytes(s, gap_max);
        repeat (3) @(negedge clk);
        check({tag, "_state"}, {61'd0, state_dbg}, {61'd0, ok ? ST_DONE : ST_ERROR});
        check({tag, "_done"}, {63'd0, done}, {63'd0, ok});
        check({tag, "_error"}, {63'd0, error}, {63'd0, !ok});
        check({tag, "_core_rst_n"}, {63'd0, core_rst_n}, {63'd0, ok});
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_ready"}, {63'd0, bif.byte_ready}, 64'd0);
        check({tag, "_word_count"}, {48'd0, word_count}, {48'd0, wc});
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        if (wr_log.size() > 0)
            check({tag, "_bus_hold"}, {bif.imem_addr, bif.imem_wdata}, wr_log[$]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {63'd0, bif.imem_we}, 64'd0);
        check({tag, "_addr_data"}, {bif.imem_addr, bif.imem_wdata}, 64'd0);
        check({tag, "_word_count"}, {48'd0, word_count}, 64'd0);
        check({tag, "_flags"}, {58'd0, bif.byte_ready, busy, done, error, core_rst_n, 1'b0}, 64'd0);
        check({tag, "_state"}, {61'd0, state_dbg}, {61'd0, ST_IDLE});
    endtask

    initial begin
        byte_q_t nom, bad, s;
        rst_n = 1'b0;
        start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_in = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", {61'd0, state_dbg}, {61'd0, ST_IDLE});

        nom = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h30};
        check("model_checksum_pin", {56'd0, data_xor(nom, 2)}, 64'h30);

        wr_log.delete();
        run_load(nom, 0, "nominal");
        check("nominal_w0", wr_log[0], {32'h0000_0000, 32'h00A0_0513});
        check("nominal_w1", wr_log[1], {32'h0000_0004, 32'h0010_0593});
        check("nominal_writes", 64'(wr_log.size()), 64'd2);

        bad = nom;
        bad[10] = 8'h37;
        wr_log.delete();
        run_load(bad, 0, "bad_sum");
        check("bad_sum_writes", 64'(wr_log.size()), 64'd2);

        run_load('{8'h00, 8'h00}, 0, "len_zero");
        run_load('{8'h05, 8'h00}, 0, "len_over");

        wr_log.delete();
        run_load(nom, 3, "throttled");
        check("throttled_w0", wr_log[0], {32'h0000_0000, 32'h00A0_0513});
        check("throttled_w1", wr_log[1], {32'h0000_0004, 32'h0010_0593});

        pulse_start();
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h05}, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wr_log.delete();
        run_load(nom, 1, "after_reset");
        check("after_reset_writes", 64'(wr_log.size()), 64'd2);

        wr_log.delete();
        run_load('{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 0, "reload");
        check("reload_w0", wr_log[0], {32'h0000_0000, 32'h0000_0013});

        for (int r = 0; r < 10; r++) begin
            int         n;
            int         kind;
            logic [7:0] x;
            logic [7:0] b;
            s.delete();
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    n = $urandom_range(1, MAX_W);
                2:       n = 0;
                default: n = $urandom_range(MAX_W + 1, 65535);
            endcase
            s.push_back(n[7:0]);
            s.push_back(n[15:8]);
            if (kind <= 1) begin
                x = 8'h00;
                for (int i = 0; i < 4 * n; i++) begin
                    b = 8'($urandom);
                    s.push_back(b);
                    x ^= b;
                end
                s.push_back(kind == 0 ? x : x ^ 8'($urandom_range(1, 255)));
            end
            run_load(s, $urandom_range(0, 3), "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
